// File: rtl/multi_digit_counter_display.sv
// multi_digit_counter_display
//   N-digit up/down counter with BCD or hex digits. A free-running prescaler
//   sets the count rate. The design also has a synchronous load and a one-cycle
//   wrap pulse. The count drives a time-multiplexed common-anode 7-segment
//   display, with one digit lit per scan slot.
// Ports
//   ClkIn   : system clock, rising edge
//   RstN    : asynchronous active-low reset
//   En      : count enable, sampled on tick cycles
//   Up      : 1 = count up, 0 = count down
//   Load    : synchronous load strobe (has priority over counting)
//   LoadVal : value to load, digit 0 in LoadVal[3:0]
//   Count   : current count, same digit packing as LoadVal
//   Wrap    : one-cycle pulse when the count overflows or underflows
//   Seg     : active-low segments, Seg[6]=a ... Seg[0]=g
//   Anode   : active-low one-hot digit select
module multi_digit_counter_display #(
  parameter int CLK_HZ   = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int MODE_BCD = 1
) (
  input  logic                  ClkIn,
  input  logic                  RstN,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Wrap,
  output logic [6:0]            Seg,
  output logic [DIGITS-1:0]     Anode
);

  localparam int DIV_T = CLK_HZ / TICK_HZ;
  localparam int DIV_S = CLK_HZ / SCAN_HZ;
  localparam int TW    = $clog2(DIV_T);
  localparam int SW    = $clog2(DIV_S);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] DIGIT_MAX = (MODE_BCD != 0) ? 4'd9 : 4'hF;

  // ---------------------------------------------------------------- prescalers
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic          tick;
  logic          scan_tick;
  logic [IW-1:0] scan_idx;

  assign tick      = (tick_cnt == TW'(DIV_T - 1));
  assign scan_tick = (scan_cnt == SW'(DIV_S - 1));

  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      tick_cnt <= '0;
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- load sanitising
  // In BCD mode a nibble above 9 would never be reached by counting, so it is
  // forced to 0 on load to keep every digit inside its legal range.
  logic [4*DIGITS-1:0] load_clean;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_load
      assign load_clean[4*gi +: 4] =
        ((MODE_BCD != 0) && (LoadVal[4*gi +: 4] > 4'd9)) ? 4'd0 : LoadVal[4*gi +: 4];
    end
  endgenerate

  // ------------------------------------------------------- ripple count step
  // One always_comb walks the digits so the carry/borrow chain stays in a
  // single process. The final carry out is exactly the wrap condition.
  logic [4*DIGITS-1:0] count_step;
  logic                carry_out;

  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_step = Count;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = Count[4*i +: 4];
      if (carry) begin
        if (Up) begin
          if (digit == DIGIT_MAX) begin
            count_step[4*i +: 4] = 4'd0;
            carry = 1'b1;
          end else begin
            count_step[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_step[4*i +: 4] = DIGIT_MAX;
            carry = 1'b1;
          end else begin
            count_step[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    carry_out = carry;
  end

  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      Count <= '0;
      Wrap  <= 1'b0;
    end else if (Load) begin
      Count <= load_clean;
      Wrap  <= 1'b0;
    end else if (tick && En) begin
      Count <= count_step;
      Wrap  <= carry_out;
    end else begin
      Wrap  <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ display
  logic [3:0]        cur_digit;
  logic [DIGITS-1:0] anode_next;
  logic [6:0]        seg_next;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_anode
      assign anode_next[gi] = (scan_idx != IW'(gi));
    end
  endgenerate

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) cur_digit = Count[4*i +: 4];
    end
  end

  always_comb begin
    seg_next = 7'b1111111;
    case (cur_digit)
      4'h0: seg_next = 7'b0000001;
      4'h1: seg_next = 7'b1001111;
      4'h2: seg_next = 7'b0010010;
      4'h3: seg_next = 7'b0000110;
      4'h4: seg_next = 7'b1001100;
      4'h5: seg_next = 7'b0100100;
      4'h6: seg_next = 7'b0100000;
      4'h7: seg_next = 7'b0001111;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0000100;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b1100000;
      4'hC: seg_next = 7'b0110001;
      4'hD: seg_next = 7'b1000010;
      4'hE: seg_next = 7'b0110000;
      4'hF: seg_next = 7'b0111000;
      default: seg_next = 7'b1111111;
    endcase
  end

  // Registered outputs: blank while in reset, one cycle behind index/Count.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      Seg   <= 7'b1111111;
      Anode <= '1;
    end else begin
      Seg   <= seg_next;
      Anode <= anode_next;
    end
  end

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// tb_multi_digit_counter_display
//   Directed bench. A BCD instance and a hex instance share the stimulus.
//   Timing is tracked as the number of clock edges since reset release.
//   Ticks land on edges 20, 40, ... and scan advances on edges 4, 8, ...
module tb_multi_digit_counter_display;

  logic        ClkIn;
  logic        RstN;
  logic        En;
  logic        Up;
  logic        Load;
  logic [15:0] LoadVal;
  logic [15:0] Count,  Count_h;
  logic        Wrap,   Wrap_h;
  logic [6:0]  Seg,    Seg_h;
  logic [3:0]  Anode,  Anode_h;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  multi_digit_counter_display #(
    .CLK_HZ(20), .TICK_HZ(1), .SCAN_HZ(5), .DIGITS(4), .MODE_BCD(1)
  ) dut_bcd (
    .ClkIn(ClkIn), .RstN(RstN), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal), .Count(Count), .Wrap(Wrap), .Seg(Seg), .Anode(Anode)
  );

  multi_digit_counter_display #(
    .CLK_HZ(20), .TICK_HZ(1), .SCAN_HZ(5), .DIGITS(4), .MODE_BCD(0)
  ) dut_hex (
    .ClkIn(ClkIn), .RstN(RstN), .En(En), .Up(Up), .Load(Load),
    .LoadVal(LoadVal), .Count(Count_h), .Wrap(Wrap_h), .Seg(Seg_h), .Anode(Anode_h)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  // Edges since reset release.
  always @(posedge ClkIn or negedge RstN) begin
    if (!RstN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, obs);
    end
  endtask

  // Advance to 1 time unit after edge number 'target'.
  task automatic go(input int target);
    while (cyc < target) begin
      @(posedge ClkIn);
      #1;
    end
  endtask

  function automatic logic [15:0] bcd16(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  logic [6:0] glyph_1234 [4];
  logic       wrap_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph_1234[0] = 7'b1001100; // 4
    glyph_1234[1] = 7'b0000110; // 3
    glyph_1234[2] = 7'b0010010; // 2
    glyph_1234[3] = 7'b1001111; // 1

    RstN = 1'b0; En = 1'b0; Up = 1'b1; Load = 1'b0; LoadVal = 16'h0000;
    repeat (2) @(posedge ClkIn);
    #1;
    check_val("rst_count", 32'(Count), 32'h0);
    check_val("rst_wrap",  32'(Wrap),  32'h0);
    check_val("rst_seg",   32'(Seg),   32'h7F);
    check_val("rst_anode", 32'(Anode), 32'hF);
    check_val("rst_anode_hex", 32'(Anode_h), 32'hF);

    // Release between edges; first edge after this is edge 1.
    @(negedge ClkIn);
    RstN = 1'b1; En = 1'b1; Up = 1'b1;

    go(1);
    check_val("first_anode", 32'(Anode), 32'hE);
    check_val("first_seg",   32'(Seg),   32'h01);

    // Test 1: free counting, one BCD step per 20 edges, no wrap.
    wrap_seen = 1'b0;
    go(19);
    check_val("t1_before_tick", 32'(Count), 32'h0000);
    for (int k = 20; k <= 200; k++) begin
      go(k);
      if (Wrap) wrap_seen = 1'b1;
      if (k % 20 == 0) check_val($sformatf("t1_count_%0d", k), 32'(Count), 32'(bcd16(k / 20)));
    end
    check_val("t1_no_wrap", 32'(wrap_seen), 32'h0);

    // Test 2: 9998 -> 9999 -> 0000 with one wrap pulse.
    Load = 1'b1; LoadVal = 16'h9998;
    go(201);
    Load = 1'b0;
    check_val("t2_loaded", 32'(Count), 32'h9998);
    go(220);
    check_val("t2_9999",      32'(Count), 32'h9999);
    check_val("t2_wrap_lo_a", 32'(Wrap),  32'h0);
    go(240);
    check_val("t2_0000",   32'(Count), 32'h0000);
    check_val("t2_wrap_hi", 32'(Wrap), 32'h1);
    go(241);
    check_val("t2_wrap_lo_b", 32'(Wrap), 32'h0);

    // Test 3: underflow in both modes, BCD load sanitising.
    Load = 1'b1; LoadVal = 16'h0000; Up = 1'b0;
    go(242);
    Load = 1'b0;
    go(259);
    check_val("t3_zero", 32'(Count), 32'h0000);
    go(260);
    check_val("t3_bcd_under",  32'(Count),   32'h9999);
    check_val("t3_bcd_wrap",   32'(Wrap),    32'h1);
    check_val("t3_hex_under",  32'(Count_h), 32'hFFFF);
    check_val("t3_hex_wrap",   32'(Wrap_h),  32'h1);
    go(261);
    check_val("t3_wrap_end", 32'(Wrap), 32'h0);
    Load = 1'b1; LoadVal = 16'h12AF;
    go(262);
    Load = 1'b0;
    check_val("t3_bcd_clean", 32'(Count),   32'h1200);
    check_val("t3_hex_raw",   32'(Count_h), 32'h12AF);

    // Test 4: load on the tick edge wins; En=0 holds across ticks.
    go(279);
    Load = 1'b1; LoadVal = 16'h0042; Up = 1'b1;
    go(280);
    Load = 1'b0; En = 1'b0;
    check_val("t4_load_on_tick", 32'(Count), 32'h0042);
    check_val("t4_no_wrap",      32'(Wrap),  32'h0);
    go(341);
    check_val("t4_hold_bcd", 32'(Count),   32'h0042);
    check_val("t4_hold_hex", 32'(Count_h), 32'h0042);

    // Test 5: scan of 1234; display after edge k shows digit ((k-1)/4)%4.
    Load = 1'b1; LoadVal = 16'h1234;
    go(342);
    Load = 1'b0;
    for (int k = 343; k <= 358; k++) begin
      int d;
      logic [3:0] exp_an;
      go(k);
      d = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << d);
      check_val($sformatf("t5_anode_%0d", k), 32'(Anode), 32'(exp_an));
      check_val($sformatf("t5_seg_%0d", k),   32'(Seg),   32'(glyph_1234[d]));
    end

    // Test 6: asynchronous reset mid-count, mid-scan.
    En = 1'b1;
    #2;
    RstN = 1'b0;
    #1;
    check_val("t6_async_count", 32'(Count), 32'h0);
    check_val("t6_async_seg",   32'(Seg),   32'h7F);
    check_val("t6_async_anode", 32'(Anode), 32'hF);
    check_val("t6_async_wrap",  32'(Wrap),  32'h0);
    repeat (2) @(posedge ClkIn);
    @(negedge ClkIn);
    RstN = 1'b1;
    go(1);
    check_val("t6_resume_anode", 32'(Anode), 32'hE);
    check_val("t6_resume_seg",   32'(Seg),   32'h01);
    check_val("t6_resume_count", 32'(Count), 32'h0000);
    go(5);
    check_val("t6_digit1_anode", 32'(Anode), 32'hD);
    check_val("t6_digit1_seg",   32'(Seg),   32'h01);
    go(19);
    check_val("t6_pre_tick", 32'(Count), 32'h0000);
    go(20);
    check_val("t6_first_tick", 32'(Count), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
